// File: rtl/fft_frame_loader_if.sv
// Sample-stream and FFT input-RAM write bus for fft_frame_loader.
// The slave side is the loader; the master side is the filter/FFT environment.
interface fft_frame_loader_if #(
    parameter int N_LOG2 = 10,
    parameter int DATA_W = 16
);
    logic                  s_valid;
    logic [DATA_W-1:0]     s_data;
    logic                  s_ready;
    logic                  ram_we;
    logic [N_LOG2-1:0]     ram_addr;
    logic [2*DATA_W-1:0]   ram_wdata;
    logic                  fft_start;
    logic                  fft_done;

    modport master (
        output s_valid, s_data, fft_done,
        input  s_ready, ram_we, ram_addr, ram_wdata, fft_start
    );

    modport slave (
        input  s_valid, s_data, fft_done,
        output s_ready, ram_we, ram_addr, ram_wdata, fft_start
    );
endinterface

// File: rtl/fft_frame_loader.sv
// Packs filtered samples into complex words, writes one N-point frame to the FFT
// input RAM, then starts the FFT. Define BIT_REVERSE_EN for bit-reversed addressing.
module fft_frame_loader #(
    parameter int N_LOG2 = 10,
    parameter int DATA_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    fft_frame_loader_if.slave       bus,
    output logic                    busy,
    output logic                    overrun,
    input  logic                    clr_overrun,
    output logic [15:0]             frame_cnt
);
    typedef enum logic [1:0] {IDLE, FILL, HAND, WAIT} state_t;

    localparam logic [N_LOG2-1:0] LAST = '1;

    state_t            state, state_next;
    logic [N_LOG2-1:0] count, count_next;
    logic              accept;

    function automatic logic [N_LOG2-1:0] addr_map(input logic [N_LOG2-1:0] c);
        logic [N_LOG2-1:0] r;
`ifdef BIT_REVERSE_EN
        for (int i = 0; i < N_LOG2; i++) r[i] = c[N_LOG2-1-i];
`else
        r = c;
`endif
        return r;
    endfunction

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        count_next  = count;
        bus.s_ready = 1'b0;
        accept      = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = FILL;
                    count_next = '0;
                end
            end
            FILL: begin
                bus.s_ready = enable;
                accept      = bus.s_valid & enable;
                if (!enable) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (accept) begin
                    // count wraps LAST -> 0 here, the only place it can
                    count_next = count + 1'b1;
                    if (count == LAST) state_next = HAND;
                end
            end
            HAND: state_next = WAIT;
            WAIT: begin
                if (bus.fft_done) begin
                    state_next = enable ? FILL : IDLE;
                    count_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; all of them reset asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.fft_start <= 1'b0;
            frame_cnt     <= '0;
            overrun       <= 1'b0;
        end else begin
            state         <= state_next;
            count         <= count_next;
            bus.ram_we    <= accept;
            if (accept) begin
                bus.ram_addr  <= addr_map(count);
                bus.ram_wdata <= {bus.s_data, {DATA_W{1'b0}}};
            end
            // fft_start follows the HAND cycle, so the last write lands first
            bus.fft_start <= (state == HAND);
            if (state == HAND) frame_cnt <= frame_cnt + 16'd1;
            if (bus.s_valid && !bus.s_ready && state != IDLE) overrun <= 1'b1;
            else if (clr_overrun)                             overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed self-checking bench for fft_frame_loader (natural or bit-reversed
// addressing, following BIT_REVERSE_EN).
module tb_fft_frame_loader;
    localparam int N_LOG2 = 10;
    localparam int DATA_W = 16;
    localparam int N      = 1 << N_LOG2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        busy;
    logic        overrun;
    logic        clr_overrun;
    logic [15:0] frame_cnt;

    int checks   = 0;
    int failures = 0;
    int start_cnt = 0;
    int we_cnt    = 0;
    int saved_we;

    fft_frame_loader_if #(.N_LOG2(N_LOG2), .DATA_W(DATA_W)) bus ();

    fft_frame_loader #(.N_LOG2(N_LOG2), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .bus         (bus),
        .busy        (busy),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.fft_start === 1'b1) start_cnt++;
        if (bus.ram_we === 1'b1)    we_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [N_LOG2-1:0] exp_addr(input int idx);
        logic [N_LOG2-1:0] c;
        logic [N_LOG2-1:0] r;
        c = N_LOG2'(idx);
`ifdef BIT_REVERSE_EN
        for (int i = 0; i < N_LOG2; i++) r[i] = c[N_LOG2-1-i];
`else
        r = c;
`endif
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers nsamp samples (base+i); with gaps, s_valid is random per cycle.
    task automatic send_samples(input int nsamp, input bit gaps, input logic [15:0] base);
        int          i;
        int          budget;
        bit          v;
        logic [15:0] d;
        i = 0;
        budget = 0;
        while (i < nsamp && budget < 8 * N) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            d = base + 16'(i);
            bus.s_valid = v;
            bus.s_data  = d;
            check("fill_ready", 32'(bus.s_ready), 32'd1);
            step();
            if (v) begin
                check("wr_we",   32'(bus.ram_we),   32'd1);
                check("wr_addr", 32'(bus.ram_addr), 32'(exp_addr(i)));
                check("wr_data", bus.ram_wdata,     {d, 16'h0000});
                i++;
            end else begin
                check("idle_we", 32'(bus.ram_we), 32'd0);
            end
            budget++;
        end
        bus.s_valid = 1'b0;
        if (i < nsamp) check("frame_timeout", 32'(i), 32'(nsamp));
    endtask

    // Called right after the last accept's write is visible (HAND cycle).
    task automatic handoff(input logic [15:0] exp_frames);
        check("hand_ready", 32'(bus.s_ready),   32'd0);
        check("hand_busy",  32'(busy),          32'd1);
        check("hand_start", 32'(bus.fft_start), 32'd0);
        step();
        check("start_pulse", 32'(bus.fft_start), 32'd1);
        check("start_fcnt",  32'(frame_cnt),     32'(exp_frames));
        check("start_we",    32'(bus.ram_we),    32'd0);
        check("start_ready", 32'(bus.s_ready),   32'd0);
        step();
        check("start_once",  32'(bus.fft_start), 32'd0);
        check("wait_busy",   32'(busy),          32'd1);
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        clr_overrun = 1'b0;
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.fft_done = 1'b0;
        #1;
        check("rst_ready", 32'(bus.s_ready),   32'd0);
        check("rst_we",    32'(bus.ram_we),    32'd0);
        check("rst_addr",  32'(bus.ram_addr),  32'd0);
        check("rst_wdata", bus.ram_wdata,      32'd0);
        check("rst_start", 32'(bus.fft_start), 32'd0);
        check("rst_busy",  32'(busy),          32'd0);
        check("rst_ovr",   32'(overrun),       32'd0);
        check("rst_fcnt",  32'(frame_cnt),     32'd0);
        step();
        step();
        rst = 1'b0;

        // IDLE: s_valid is not an overrun and nothing is written
        bus.s_valid = 1'b1;
        step();
        bus.s_valid = 1'b0;
        check("idle_busy",  32'(busy),        32'd0);
        check("idle_ready", 32'(bus.s_ready), 32'd0);
        check("idle_ovr",   32'(overrun),     32'd0);
        check("idle_we",    32'(bus.ram_we),  32'd0);

        // Full back-to-back frame, data = i
        enable = 1'b1;
        step();
        check("fill_busy", 32'(busy), 32'd1);
        send_samples(N, 1'b0, 16'h0000);
        handoff(16'd1);
        check("start_cnt1", 32'(start_cnt), 32'd1);

        // WAIT: offered samples are refused and flagged
        saved_we = we_cnt;
        bus.s_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("wait_ready", 32'(bus.s_ready), 32'd0);
            step();
        end
        bus.s_valid = 1'b0;
        check("wait_no_we", 32'(we_cnt),    32'(saved_we));
        check("wait_ovr",   32'(overrun),   32'd1);
        check("wait_start", 32'(start_cnt), 32'd1);
        clr_overrun = 1'b1;
        step();
        check("ovr_clear", 32'(overrun), 32'd0);
        bus.s_valid = 1'b1;
        step();
        check("ovr_set_wins", 32'(overrun), 32'd1);
        bus.s_valid = 1'b0;
        step();
        clr_overrun = 1'b0;
        check("ovr_clear2", 32'(overrun), 32'd0);

        // fft_done with enable -> next frame, random 50% valid, negative data
        bus.fft_done = 1'b1;
        step();
        bus.fft_done = 1'b0;
        check("done_fill_ready", 32'(bus.s_ready), 32'd1);
        send_samples(N, 1'b1, 16'h8000);
        handoff(16'd2);
        check("start_cnt2", 32'(start_cnt), 32'd2);
        check("frame2_we",  32'(we_cnt),    32'(2 * N));

        // fft_done with enable low -> IDLE
        enable = 1'b0;
        bus.fft_done = 1'b1;
        step();
        bus.fft_done = 1'b0;
        check("done_idle_busy", 32'(busy), 32'd0);

        // fft_done outside WAIT is ignored
        enable = 1'b1;
        step();
        bus.fft_done = 1'b1;
        step();
        bus.fft_done = 1'b0;
        check("done_fill_busy",  32'(busy),        32'd1);
        check("done_fill_ready", 32'(bus.s_ready), 32'd1);

        // Abort after 300 samples
        send_samples(300, 1'b0, 16'h0100);
        enable = 1'b0;
        #1;
        check("abort_ready", 32'(bus.s_ready), 32'd0);
        step();
        check("abort_busy", 32'(busy), 32'd0);
        step();
        step();
        check("abort_start", 32'(start_cnt), 32'd2);
        check("abort_fcnt",  32'(frame_cnt), 32'd2);
        enable = 1'b1;
        step();
        send_samples(N, 1'b0, 16'h7FF0);
        handoff(16'd3);
        check("start_cnt3", 32'(start_cnt), 32'd3);

        // Async reset mid-FILL, between edges
        bus.fft_done = 1'b1;
        step();
        bus.fft_done = 1'b0;
        send_samples(10, 1'b0, 16'h0042);
        check("pre_rst_we", 32'(bus.ram_we), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_ready", 32'(bus.s_ready),   32'd0);
        check("arst_we",    32'(bus.ram_we),    32'd0);
        check("arst_busy",  32'(busy),          32'd0);
        check("arst_start", 32'(bus.fft_start), 32'd0);
        check("arst_fcnt",  32'(frame_cnt),     32'd0);
        step();
        rst = 1'b0;
        enable = 1'b0;
        step();
        step();
        check("arst_idle",       32'(busy),      32'd0);
        check("arst_no_start",   32'(start_cnt), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
